// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: locked tenures, round-robin on contention,
// and a per-tenure watchdog that answers a stalled strobe with a bus error.
module wb_arbiter #(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cyc,
  input  logic             m1_cyc,
  input  logic             m0_stb,
  input  logic             m1_stb,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m0_dat_w,
  input  logic [DAT_W-1:0] m1_dat_w,
  output logic [DAT_W-1:0] m0_dat_r,
  output logic [DAT_W-1:0] m1_dat_r,
  output logic             m0_ack,
  output logic             m1_ack,
  output logic             m0_err,
  output logic             m1_err,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_w,
  input  logic [DAT_W-1:0] s_dat_r,
  input  logic             s_ack,
  output logic [1:0]       gnt
);

  localparam bit            WD_EN = (TIMEOUT > 0);
  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS0 = 2'd1, BUS1 = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic             sel_cyc, sel_stb, sel_we;
  logic [ADR_W-1:0] sel_adr;
  logic [DAT_W-1:0] sel_dat;
  logic             stb_raw, fwd_ack, tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_err  = 1'b0;
    stb_raw = 1'b0;
    fwd_ack = 1'b0;
    tmo     = 1'b0;
    sel_cyc = (state_q == BUS1) ? m1_cyc   : m0_cyc;
    sel_stb = (state_q == BUS1) ? m1_stb   : m0_stb;
    sel_we  = (state_q == BUS1) ? m1_we    : m0_we;
    sel_adr = (state_q == BUS1) ? m1_adr   : m0_adr;
    sel_dat = (state_q == BUS1) ? m1_dat_w : m0_dat_w;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On contention last_q names the previous owner; the other one wins.
        if (m0_cyc && (!m1_cyc || last_q)) state_d = BUS0;
        else if (m1_cyc)                   state_d = BUS1;
      end
      BUS0, BUS1: begin
        // Gating with cyc keeps an ack in the release cycle from reaching the master.
        stb_raw = sel_cyc & sel_stb;
        fwd_ack = stb_raw & s_ack;
        tmo     = WD_EN && (cnt_q == TO_V) && stb_raw && !s_ack;
        s_cyc   = sel_cyc;
        s_stb   = stb_raw & ~tmo;
        s_we    = sel_we;
        s_adr   = sel_adr;
        s_dat_w = sel_dat;
        if (state_q == BUS0) begin
          m0_ack = fwd_ack;
          m0_err = tmo;
        end else begin
          m1_ack = fwd_ack;
          m1_err = tmo;
        end
        if (fwd_ack || tmo)       cnt_d = '0;
        else if (stb_raw && WD_EN) cnt_d = cnt_q + CW'(1);
        if (!sel_cyc) begin
          state_d = IDLE;
          last_d  = (state_q == BUS1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt      = {state_q == BUS1, state_q == BUS0};
  assign m0_dat_r = rst ? '0 : s_dat_r;
  assign m1_dat_r = rst ? '0 : s_dat_r;

endmodule
